spi_mem_master: RTL and testbench
=================================

Name: spi_mem_master

Overview:
- SPI master that executes the memory transactions requested by the CPU control FSM: instruction fetches, data reads and data writes.
- Accepts a start strobe with direction, address and write data.
- Runs one fixed 32-SCK-cycle SPI Mode 0 frame per request, then returns read data with a one-cycle done pulse the control path uses to advance or release halt.
- Sits between the control/datapath and the external SPI memory.

Parameters:
- ADDR_W, 15: address field width; ADDR_W + DATA_W + 1 must equal 32.
- DATA_W, 16: data field width (Hack word).
- HALF_DIV, 2: clk cycles per SCK half-period; legal range is 1 or greater.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  request strobe; sampled only in IDLE
- rwb_i  in  1  1 = read, 0 = write; latched at accept
- addr_i  in  ADDR_W  memory address; latched at accept
- wdata_i  in  DATA_W  write data; latched at accept
- rdata_o  out  DATA_W  last read data; holds its value between reads
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- sclk_o  out  1  SPI clock, idle low
- cs_n_o  out  1  chip select, active low
- mosi_o  out  1  serial data out
- miso_i  in  1  serial data in

Behaviour:
- Reset: synchronous and active-high; clk is the only clock.
- Reset values: state IDLE, sclk_o=0, cs_n_o=1, mosi_o=0, busy_o=0, done_o=0, rdata_o=0, internal counters 0.
- Reset asserted mid-frame aborts the frame at the next edge. No done_o pulse; rdata_o clears to 0.
- Frame format, MSB first, 32 bits: tx = {rwb, addr[ADDR_W-1:0], data}.
  - data = wdata for a write.
  - data = all zeros for a read.
- States:
  - IDLE: cs_n=1, sclk=0. When start_i=1, latch tx into the shift register, clear the rx shift register, drive mosi_o=tx[31], go to LEAD. cs_n_o goes low on the same edge.
  - LEAD: hold for HALF_DIV cycles with sclk=0 (CS setup), then go to SHIFT.
  - SHIFT: produce 32 SCK pulses. Each pulse is HALF_DIV cycles high followed by HALF_DIV cycles low.
    - On the edge that raises sclk_o, shift miso_i into the rx LSB.
    - On the edge that lowers sclk_o, shift tx left and drive the next bit on mosi_o.
    - After the 32nd falling edge mosi_o=0; go to TRAIL.
  - TRAIL: hold for HALF_DIV cycles with cs low and sclk=0, then go to DONE.
  - DONE: exactly one cycle with cs_n=1, done_o=1, busy_o=1.
    - Read frame: rdata_o = rx[DATA_W-1:0], i.e. the bits sampled on SCK pulses 17..32, registered on the edge entering DONE.
    - Write frame: rdata_o unchanged.
    - Next state is IDLE.
- Latency: done_o is high during the cycle that starts 66*HALF_DIV+1 edges after the accepting edge; for HALF_DIV=2, that is 133 edges.
- Minimum CS-high gap between frames is 2 cycles (DONE plus IDLE accept).
- start_i while busy_o=1 is ignored and is not queued.
- start_i asserted in the DONE cycle is ignored.
- start_i held high continuously gives back-to-back frames, one accepted per IDLE cycle.
- All outputs are registered; sclk_o, cs_n_o and mosi_o come directly from flops and are glitch-free.
- The bit counter is 6 bits and counts 0..31 without wrapping; the half-period counter counts 0..HALF_DIV-1.

Optional Feature:
- Macro: SPI_TXN_COUNT_EN.
- Defined:
  - Adds output txn_count_o, 16 bits.
  - Reset value 0.
  - Increments by 1 on the edge entering DONE, for both reads and writes.
  - Wraps from 0xFFFF to 0x0000.
  - Not incremented on an aborted frame.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles -> cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rdata_o=0x0000.
- Write, HALF_DIV=2: rwb=0, addr=0x1234, wdata=0xBEEF -> 32 SCK pulses, each 4 clk cycles; MOSI word captured on rising edges = 0x1234BEEF; done_o single pulse at edge 133 after accept; rdata_o unchanged.
- Read: rwb=1, addr=0x0005, memory model drives 0xA5C3 on MISO during pulses 17..32 -> MOSI word = 0x80050000; rdata_o=0xA5C3 in the done cycle, and it holds afterwards.
- start_i pulsed mid-frame and again in the DONE cycle -> both ignored; exactly one frame; the next frame starts only after IDLE.
- Reset asserted at SCK pulse 10 of a read -> next edge cs_n_o=1, sclk_o=0, busy_o=0, no done_o; a following read returns correct data.
- SPI_TXN_COUNT_EN defined, counter preloaded near wrap by running 0xFFFF frames with HALF_DIV=1 (or via force) -> txn_count_o goes 0xFFFF to 0x0000 on the next done; an aborted frame leaves it unchanged.

Source files
------------

// File: rtl/spi_mem_master_if.sv
// Bus bundle for spi_mem_master: CPU-side request/response handshake plus
// the four SPI memory pins. The master modport is the SPI master's view;
// the slave modport is the view of the environment (control FSM + memory).
interface spi_mem_master_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              start_i;
    logic              rwb_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              done_o;
    logic              sclk_o;
    logic              cs_n_o;
    logic              mosi_o;
    logic              miso_i;

    modport master (
        input  start_i, rwb_i, addr_i, wdata_i, miso_i,
        output rdata_o, busy_o, done_o, sclk_o, cs_n_o, mosi_o
    );

    modport slave (
        output start_i, rwb_i, addr_i, wdata_i, miso_i,
        input  rdata_o, busy_o, done_o, sclk_o, cs_n_o, mosi_o
    );
endinterface

// File: rtl/spi_mem_master.sv
// SPI Mode 0 memory master. One request = one fixed 32-bit frame
// {rwb, addr, data}, MSB first; read data is the last DATA_W bits sampled
// on MISO. Frame: LEAD (CS setup), 32 SCK pulses, TRAIL (CS hold), then a
// single DONE cycle with cs_n high and done_o pulsed.
// ADDR_W + DATA_W + 1 must equal 32; HALF_DIV >= 1.
// Optional feature macro: SPI_TXN_COUNT_EN adds txn_count_o, a 16-bit
// wrapping count of completed frames.
module spi_mem_master #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef SPI_TXN_COUNT_EN
    output logic [15:0] txn_count_o,
`endif
    spi_mem_master_if.master bus
);

    localparam int FRAME_W = ADDR_W + DATA_W + 1;
    localparam int HALF_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [HALF_W-1:0]   r_half;
    logic [5:0]          r_bit;
    logic                r_last;
    logic                r_rwb;
    logic [FRAME_W-2:0]  r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_sclk;
    logic                r_cs_n;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;

    logic                w_half_end;
    logic [DATA_W-1:0]   w_data;
    logic [FRAME_W-1:0]  w_tx;

    assign w_half_end = (r_half == HALF_W'(HALF_DIV - 1));

    // Frame word as it would be launched if the request were accepted now.
    always_comb begin
        w_data = bus.wdata_i;
        if (bus.rwb_i) begin
            w_data = '0;
        end
        w_tx = {bus.rwb_i, bus.addr_i, w_data};
    end

    // Frame sequencer. Entering SHIFT with the half counter at its terminal
    // value makes the first SHIFT cycle the tail of a low phase, so the
    // first SCK rise follows one cycle later. The 32nd pulse keeps its full
    // low half inside SHIFT (r_last marks it) before TRAIL begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_half  <= '0;
            r_bit   <= '0;
            r_last  <= 1'b0;
            r_rwb   <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= 1'b0;
                    r_cs_n <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.start_i) begin
                        r_tx    <= w_tx[FRAME_W-2:0];
                        r_mosi  <= w_tx[FRAME_W-1];
                        r_rx    <= '0;
                        r_rwb   <= bus.rwb_i;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_half  <= '0;
                        r_bit   <= '0;
                        r_last  <= 1'b0;
                        r_state <= S_LEAD;
                    end
                end

                S_LEAD: begin
                    if (w_half_end) begin
                        r_half  <= HALF_W'(HALF_DIV - 1);
                        r_state <= S_SHIFT;
                    end else begin
                        r_half <= r_half + HALF_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (w_half_end) begin
                        r_half <= '0;
                        if (!r_sclk) begin
                            if (r_last) begin
                                r_state <= S_TRAIL;
                            end else begin
                                r_sclk <= 1'b1;
                                r_rx   <= {r_rx[DATA_W-2:0], bus.miso_i};
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            r_tx   <= {r_tx[FRAME_W-3:0], 1'b0};
                            if (r_bit == 6'(FRAME_W - 1)) begin
                                r_last <= 1'b1;
                                r_mosi <= 1'b0;
                            end else begin
                                r_bit  <= r_bit + 6'd1;
                                r_mosi <= r_tx[FRAME_W-2];
                            end
                        end
                    end else begin
                        r_half <= r_half + HALF_W'(1);
                    end
                end

                S_TRAIL: begin
                    if (w_half_end) begin
                        r_half  <= '0;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        if (r_rwb) begin
                            r_rdata <= r_rx;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_half <= r_half + HALF_W'(1);
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_bit   <= '0;
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_TXN_COUNT_EN
    logic [15:0] r_txn_count;

    // Count frames on the edge entering DONE; an aborted frame never gets there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txn_count <= '0;
        end else if (r_state == S_TRAIL && w_half_end) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    assign txn_count_o = r_txn_count;
`endif

    assign bus.rdata_o = r_rdata;
    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;
    assign bus.sclk_o  = r_sclk;
    assign bus.cs_n_o  = r_cs_n;
    assign bus.mosi_o  = r_mosi;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master (HALF_DIV=2): table of frames with a MISO memory
// model, scoreboard of expected MOSI word / rdata, plus hand sequences for
// ignored starts, back-to-back frames, mid-frame reset and the optional
// transaction counter (SPI_TXN_COUNT_EN).
module tb_spi_mem_master;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int HD     = 2;
    localparam int LAT    = 66 * HD + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SPI_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    spi_mem_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HALF_DIV(HD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SPI_TXN_COUNT_EN
        .txn_count_o(txn_count),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic              rwb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [31:0]       miso_word;
        logic [31:0]       exp_mosi;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0]       mosi;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    vec_t v;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one request and act as the SPI memory until done (or abort).
    task automatic run_frame(input vec_t fv, input bit mid_start, input bit keep_start,
                             input int abort_at);
        exp_t        e;
        exp_t        got;
        int          cyc       = 0;
        int          pulses    = 0;
        int          high_run  = 0;
        int          low_run   = 0;
        int          width_err = 0;
        int          cs_err    = 0;
        int          done_cyc  = -1;
        bit          aborted   = 1'b0;
        logic        prev_sclk = 1'b0;
        logic [31:0] mosi_word = '0;

        e.mosi  = fv.exp_mosi;
        e.rdata = fv.exp_rdata;
        sb.push_back(e);

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rwb_i   = fv.rwb;
        bus.addr_i  = fv.addr;
        bus.wdata_i = fv.wdata;
        bus.miso_i  = fv.miso_word[31];
        @(posedge clk);
        #1;
        if (!keep_start) bus.start_i = 1'b0;

        while (done_cyc < 0 && !aborted && cyc < LAT + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.sclk_o && !prev_sclk) begin
                pulses++;
                mosi_word = {mosi_word[30:0], bus.mosi_o};
                if (pulses > 1 && low_run != HD) width_err++;
                high_run = 0;
            end
            if (!bus.sclk_o && prev_sclk) begin
                if (high_run != HD) width_err++;
                low_run = 0;
            end
            if (bus.sclk_o) high_run++;
            else low_run++;
            prev_sclk = bus.sclk_o;
            if (pulses < 32) bus.miso_i = fv.miso_word[31 - pulses];
            if (bus.cs_n_o && !bus.done_o) cs_err++;
            if (mid_start) begin
                if (cyc == 40) begin
                    bus.start_i = 1'b1;
                    bus.addr_i  = ~fv.addr;
                    bus.wdata_i = ~fv.wdata;
                    bus.rwb_i   = ~fv.rwb;
                end else if (cyc == 41) begin
                    bus.start_i = 1'b0;
                end
            end
            if (abort_at > 0 && pulses == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                chk("abort_cs_n", bus.cs_n_o, 1);
                chk("abort_sclk", bus.sclk_o, 0);
                chk("abort_busy", bus.busy_o, 0);
                chk("abort_done", bus.done_o, 0);
                chk("abort_rdata", bus.rdata_o, 0);
                aborted = 1'b1;
            end
            if (bus.done_o) done_cyc = cyc;
        end

        got = sb.pop_front();
        if (aborted) begin
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.done_o || bus.busy_o) width_err++;
            end
            chk("abort_quiet", width_err, 0);
            return;
        end

        chk("done_latency", done_cyc, LAT);
        chk("sck_pulses", pulses, 32);
        chk("sck_width_err", width_err, 0);
        chk("cs_low_err", cs_err, 0);
        chk("mosi_word", mosi_word, got.mosi);
        chk("rdata_done", bus.rdata_o, got.rdata);
        chk("busy_in_done", bus.busy_o, 1);
        chk("cs_n_in_done", bus.cs_n_o, 1);
        if (mid_start) bus.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (mid_start) bus.start_i = 1'b0;
        chk("done_pulse_len", bus.done_o, 0);
        chk("busy_after", bus.busy_o, 0);
        chk("rdata_hold", bus.rdata_o, got.rdata);
        if (mid_start) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("no_extra_busy", bus.busy_o, 0);
            chk("no_extra_cs", bus.cs_n_o, 1);
        end
    endtask

    initial begin
        int cyc;

        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.rwb_i   = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        bus.miso_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", bus.cs_n_o, 1);
        chk("rst_sclk", bus.sclk_o, 0);
        chk("rst_mosi", bus.mosi_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);

        //            rwb   addr       wdata      miso_word      exp_mosi       exp_rdata
        vecs[0] = '{1'b0, 15'h1234, 16'hBEEF, 32'hDEADBEEF, 32'h1234BEEF, 16'h0000};
        vecs[1] = '{1'b1, 15'h0005, 16'h0000, 32'h5A5AA5C3, 32'h80050000, 16'hA5C3};
        vecs[2] = '{1'b0, 15'h7FFF, 16'hFFFF, 32'h00000000, 32'h7FFFFFFF, 16'hA5C3};
        vecs[3] = '{1'b1, 15'h7FFF, 16'h1111, 32'h00000001, 32'hFFFF0000, 16'h0001};
        vecs[4] = '{1'b1, 15'h0000, 16'h0000, 32'hFFFF8000, 32'h80000000, 16'h8000};
        vecs[5] = '{1'b0, 15'h0000, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 16'h8000};

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0, 1'b0, 0);
        end

        // Start pulsed mid-frame (with changed inputs) and in the DONE cycle.
        v = '{1'b1, 15'h0ABC, 16'h5555, 32'h00001234, 32'h8ABC0000, 16'h1234};
        run_frame(v, 1'b1, 1'b0, 0);

        // start_i held high: second accept on the IDLE cycle after DONE.
        v = '{1'b0, 15'h0001, 16'h00FF, 32'h00000000, 32'h000100FF, 16'h1234};
        run_frame(v, 1'b0, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_busy", bus.busy_o, 1);
        chk("b2b_cs_n", bus.cs_n_o, 0);
        bus.start_i = 1'b0;
        cyc = 0;
        while (!bus.done_o && cyc < LAT + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("b2b_latency", cyc, LAT);
        chk("b2b_rdata", bus.rdata_o, 16'h1234);
        @(posedge clk);
        @(negedge clk);

        // Reset during SCK pulse 10 of a read, then a clean read.
        v = '{1'b1, 15'h0005, 16'h0000, 32'hFFFFFFFF, 32'h80050000, 16'hFFFF};
        run_frame(v, 1'b0, 1'b0, 10);
        v = '{1'b1, 15'h0005, 16'h0000, 32'h0000A5C3, 32'h80050000, 16'hA5C3};
        run_frame(v, 1'b0, 1'b0, 0);

`ifdef SPI_TXN_COUNT_EN
        @(negedge clk);
        force dut.r_txn_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_txn_count;
        v = '{1'b0, 15'h0002, 16'h0003, 32'h00000000, 32'h00020003, 16'hA5C3};
        run_frame(v, 1'b0, 1'b0, 0);
        chk("txn_ffff", txn_count, 16'hFFFF);
        run_frame(v, 1'b0, 1'b0, 0);
        chk("txn_wrap", txn_count, 16'h0000);
        v = '{1'b1, 15'h0005, 16'h0000, 32'hFFFFFFFF, 32'h80050000, 16'h0000};
        run_frame(v, 1'b0, 1'b0, 10);
        chk("txn_abort", txn_count, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
